// File: rtl/temp_led_driver.sv
// Raw temperature sample -> sign + 3-digit BCD via sequential double-dabble,
// debounced colour band, and an RGB PWM LED that fades toward the band colour.
module temp_led_driver #(
  parameter int TEMP_W   = 13,
  parameter int PWM_W    = 8,
  parameter int FADE_DIV = 1024,
  parameter int STABLE_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_raw,
  output logic              busy,
  output logic              bcd_valid,
  output logic              temp_sign,
  output logic [3:0]        temp_h,
  output logic [3:0]        temp_t,
  output logic [3:0]        temp_u,
  output logic [2:0]        band,
  output logic [2:0]        led
);

  localparam int CW    = (STABLE_N > 1) ? $clog2(STABLE_N + 1) : 1;
  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int SH    = (PWM_W >= 8) ? 0 : 8 - PWM_W;
  localparam logic [PWM_W-1:0] PWM_TOP = {{(PWM_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        iter;
  logic [20:0]       dd;          // {hundreds, tens, units, binary}
  logic [8:0]        mag;
  logic              neg;
  logic [TEMP_W:0]   raw_ext, raw_abs;
  logic [8:0]        mag_in;
  logic              busy_nxt;
  logic [2:0]        cand, prev_cand;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [23:0]       rgb;
  logic [PWM_W-1:0]  tgt_r, tgt_g, tgt_b;
  logic [PWM_W-1:0]  cur_r, cur_g, cur_b;
  logic [PWM_W-1:0]  duty_r, duty_g, duty_b;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [PRE_W-1:0]  pre;

  function automatic logic [20:0] dd_step(input logic [20:0] v);
    logic [20:0] a;
    a = v;
    for (int i = 0; i < 3; i++)
      if (a[9+4*i +: 4] >= 4'd5) a[9+4*i +: 4] = a[9+4*i +: 4] + 4'd3;
    return {a[19:0], 1'b0};
  endfunction

  function automatic logic [23:0] band_rgb(input logic [2:0] b);
    case (b)
      3'd0:    return 24'h180DF3;
      3'd1:    return 24'h15D7EB;
      3'd2:    return 24'h22DE6E;
      3'd3:    return 24'h43C739;
      3'd4:    return 24'hDA6D00;
      3'd5:    return 24'hFF1900;
      default: return 24'hFF0000;
    endcase
  endfunction

  function automatic logic [PWM_W-1:0] chan(input logic [7:0] f);
    return PWM_W'(f >> SH);
  endfunction

  function automatic logic [PWM_W-1:0] fade(input logic [PWM_W-1:0] c, input logic [PWM_W-1:0] t);
    if (c < t) return c + PWM_W'(1);
    if (c > t) return c - PWM_W'(1);
    return c;
  endfunction

  // Magnitude truncates toward zero: |raw| first, then drop the fraction.
  assign raw_ext = {temp_raw[TEMP_W-1], temp_raw};
  assign raw_abs = raw_ext[TEMP_W] ? -raw_ext : raw_ext;
  assign mag_in  = 9'(raw_abs >> 4);

  always_comb begin
    cand = 3'd6;
    if (neg || mag <= 9'd10) cand = 3'd0;
    else if (mag <= 9'd15)   cand = 3'd1;
    else if (mag <= 9'd20)   cand = 3'd2;
    else if (mag <= 9'd25)   cand = 3'd3;
    else if (mag <= 9'd30)   cand = 3'd4;
    else if (mag <= 9'd38)   cand = 3'd5;
  end

  always_comb begin
    cnt_nxt = CW'(0);
    if (cand != band) cnt_nxt = (cand == prev_cand) ? cnt + CW'(1) : CW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (temp_valid) state_nxt = CONV;
      CONV:    if (iter == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy stays high through the DONE cycle so it covers the bcd_valid edge.
  assign busy_nxt = (state_nxt != IDLE) || (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      temp_sign <= 1'b0;
      temp_h    <= 4'd0;
      temp_t    <= 4'd0;
      temp_u    <= 4'd0;
      band      <= 3'd0;
      prev_cand <= 3'd0;
      cnt       <= CW'(0);
      iter      <= 4'd0;
      dd        <= 21'd0;
      mag       <= 9'd0;
      neg       <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      bcd_valid <= 1'b0;
      case (state)
        IDLE: if (temp_valid) begin
          dd   <= {12'd0, mag_in};
          mag  <= mag_in;
          neg  <= temp_raw[TEMP_W-1];
          iter <= 4'd0;
        end
        CONV: begin
          dd   <= dd_step(dd);
          iter <= iter + 4'd1;
        end
        DONE: begin
          temp_h    <= dd[20:17];
          temp_t    <= dd[16:13];
          temp_u    <= dd[12:9];
          temp_sign <= neg;
          bcd_valid <= 1'b1;
          prev_cand <= cand;
          if (cnt_nxt == CW'(STABLE_N)) begin
            band <= cand;
            cnt  <= CW'(0);
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign rgb   = band_rgb(band);
  assign tgt_r = chan(rgb[23:16]);
  assign tgt_g = chan(rgb[15:8]);
  assign tgt_b = chan(rgb[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= PRE_W'(0);
      cur_r   <= PWM_W'(0);
      cur_g   <= PWM_W'(0);
      cur_b   <= PWM_W'(0);
      pwm_cnt <= PWM_W'(0);
      duty_r  <= PWM_W'(0);
      duty_g  <= PWM_W'(0);
      duty_b  <= PWM_W'(0);
    end else begin
      if (pre == PRE_W'(FADE_DIV - 1)) begin
        pre   <= PRE_W'(0);
        cur_r <= fade(cur_r, tgt_r);
        cur_g <= fade(cur_g, tgt_g);
        cur_b <= fade(cur_b, tgt_b);
      end else begin
        pre <= pre + PRE_W'(1);
      end
      // Duty only reloads at period start so a period is never split.
      if (pwm_cnt == PWM_W'(0)) begin
        duty_r <= cur_r;
        duty_g <= cur_g;
        duty_b <= cur_b;
      end
      pwm_cnt <= (pwm_cnt == PWM_TOP) ? PWM_W'(0) : pwm_cnt + PWM_W'(1);
    end
  end

  assign led = {pwm_cnt < duty_r, pwm_cnt < duty_g, pwm_cnt < duty_b};

endmodule

// File: tb/tb_temp_led_driver.sv
// Directed bench for temp_led_driver: conversion timing/digits, debounce,
// dropped samples, mid-conversion reset and PWM colour duty.
module tb_temp_led_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        temp_valid;
  logic [12:0] temp_raw;
  logic        busy, bcd_valid, temp_sign;
  logic [3:0]  temp_h, temp_t, temp_u;
  logic [2:0]  band, led;

  int n_assert = 0;
  int n_fail   = 0;

  temp_led_driver #(.TEMP_W(13), .PWM_W(8), .FADE_DIV(4), .STABLE_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .temp_raw(temp_raw),
    .busy(busy), .bcd_valid(bcd_valid), .temp_sign(temp_sign),
    .temp_h(temp_h), .temp_t(temp_t), .temp_u(temp_u),
    .band(band), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bcd_valid"}, bcd_valid, 0);
    chk({tag, "_sign"}, temp_sign, 0);
    chk({tag, "_digits"}, {temp_h, temp_t, temp_u}, 0);
    chk({tag, "_band"}, band, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  // One sample at edge N; checks busy N..N+10, a single bcd_valid at N+10,
  // the result, band, and idle at N+11. Optionally injects a sample at N+3.
  task automatic run_conv(input string tag, input logic [12:0] raw, input bit inject,
                          input logic sgn, input logic [11:0] digits, input logic [2:0] exp_band);
    int nv;
    @(posedge clk); #1;
    temp_valid = 1'b1; temp_raw = raw;
    @(posedge clk); #1;
    temp_valid = 1'b0;
    chk({tag, "_busy_N"}, busy, 1);
    nv = 0;
    for (int k = 1; k <= 10; k++) begin
      if (inject && k == 3) begin
        temp_valid = 1'b1; temp_raw = 13'h0630;
      end
      @(posedge clk); #1;
      temp_valid = 1'b0;
      if (bcd_valid) nv++;
      if (k < 10) chk({tag, "_busy_mid"}, busy, 1);
    end
    chk({tag, "_busy_N10"}, busy, 1);
    chk({tag, "_bcd_valid_N10"}, bcd_valid, 1);
    chk({tag, "_sign"}, temp_sign, sgn);
    chk({tag, "_digits"}, {temp_h, temp_t, temp_u}, digits);
    chk({tag, "_band"}, band, exp_band);
    @(posedge clk); #1;
    chk({tag, "_busy_N11"}, busy, 0);
    chk({tag, "_bcd_valid_N11"}, bcd_valid, 0);
    if (inject) begin
      repeat (12) begin
        @(posedge clk); #1;
        if (bcd_valid) nv++;
      end
      chk({tag, "_busy_after_drop"}, busy, 0);
    end
    chk({tag, "_bcd_valid_count"}, nv, 1);
  endtask

  task automatic measure_duty(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (255) begin
      @(posedge clk); #1;
      r += int'(led[2]); g += int'(led[1]); b += int'(led[0]);
    end
  endtask

  initial begin
    int r, g, b, nv;
    rst_n = 1'b0; temp_valid = 1'b0; temp_raw = 13'h0;
    #23;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Band 0 colour 18/0D/F3 after the fade settles.
    repeat (1300) @(posedge clk);
    #1;
    measure_duty(r, g, b);
    chk("duty_band0_r", r, 24);
    chk("duty_band0_g", g, 13);
    chk("duty_band0_b", b, 243);

    run_conv("t25",    13'h0190, 1'b0, 1'b0, 12'h025, 3'd0);
    run_conv("tm1",    13'h1FF0, 1'b0, 1'b1, 12'h001, 3'd0);
    run_conv("tm256",  13'h1000, 1'b0, 1'b1, 12'h256, 3'd0);
    run_conv("tm0p9",  13'h1FF1, 1'b0, 1'b1, 12'h000, 3'd0);

    // Three consecutive 25 C results (the first with a dropped sample) -> band 3.
    run_conv("drop25", 13'h0190, 1'b1, 1'b0, 12'h025, 3'd0);
    run_conv("b3_2",   13'h0190, 1'b0, 1'b0, 12'h025, 3'd0);
    run_conv("b3_3",   13'h0190, 1'b0, 1'b0, 12'h025, 3'd3);

    // Reset at N+5 of a conversion.
    @(posedge clk); #1;
    temp_valid = 1'b1; temp_raw = 13'h0270;
    @(posedge clk); #1;
    temp_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    nv = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bcd_valid) nv++;
    end
    chk("midreset_no_bcd_valid", nv, 0);
    chk("midreset_band", band, 0);

    run_conv("t12",    13'h00C0, 1'b0, 1'b0, 12'h012, 3'd0);
    run_conv("alt25a", 13'h0190, 1'b0, 1'b0, 12'h025, 3'd0);
    run_conv("alt12a", 13'h00C0, 1'b0, 1'b0, 12'h012, 3'd0);
    run_conv("alt25b", 13'h0190, 1'b0, 1'b0, 12'h025, 3'd0);
    run_conv("alt12b", 13'h00C0, 1'b0, 1'b0, 12'h012, 3'd0);

    run_conv("t38a",   13'h0260, 1'b0, 1'b0, 12'h038, 3'd0);
    run_conv("t38b",   13'h026F, 1'b0, 1'b0, 12'h038, 3'd0);
    run_conv("t38c",   13'h0260, 1'b0, 1'b0, 12'h038, 3'd5);

    run_conv("t39a",   13'h0270, 1'b0, 1'b0, 12'h039, 3'd5);
    run_conv("t255",   13'h0FFF, 1'b0, 1'b0, 12'h255, 3'd5);
    run_conv("t39c",   13'h0278, 1'b0, 1'b0, 12'h039, 3'd6);

    // Band 6 = FF/00/00: red fully on, green and blue fully off.
    repeat (1400) @(posedge clk);
    #1;
    measure_duty(r, g, b);
    chk("duty_band6_r", r, 255);
    chk("duty_band6_g", g, 0);
    chk("duty_band6_b", b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_led_driver.md
# temp_led_driver

Parametrised successor to the team's temperature translator. It takes signed raw sensor samples (1/16 °C per LSB) through a valid-qualified input and converts each to sign plus three BCD digits with a sequential double-dabble engine. It classifies the temperature into one of seven colour bands, with debounce on band changes. It drives an RGB LED through PWM that fades smoothly toward the band colour. It sits between the temperature sensor interface and the display/LED outputs.

## Interface
Parameters:
- TEMP_W, 13, raw sample width, two's complement, LSB = 1/16 °C (8 ≤ TEMP_W ≤ 13)
- PWM_W, 8, colour channel resolution; PWM period = 2^PWM_W − 1 cycles
- FADE_DIV, 1024, cycles between fade steps (≥ 1)
- STABLE_N, 3, consecutive conversions required to change band (≥ 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- temp_valid  in  1  sample strobe, one cycle
- temp_raw  in  TEMP_W  raw signed sample
- busy  out  1  conversion in progress
- bcd_valid  out  1  one-cycle pulse, digits updated
- temp_sign  out  1  1 = negative
- temp_h, temp_t, temp_u  out  4 each  hundreds/tens/units BCD of |T|
- band  out  3  current debounced band, 0..6
- led  out  3  {R,G,B} PWM outputs

## Operation
- Integer temperature: mag = |temp_raw| >> 4 (truncation toward zero), 9 bits. temp_sign = MSB of temp_raw. Raw −1..−15 gives sign 1, mag 0.
- FSM IDLE → CONV → DONE → IDLE.
  - IDLE: a temp_valid capture loads mag and sign, then → CONV.
  - CONV: 9 double-dabble iterations, one per cycle. Add 3 to each nibble ≥ 5, then shift.
  - DONE: register the digits and temp_sign, pulse bcd_valid, evaluate the band candidate, then → IDLE.
- temp_valid outside IDLE is ignored and dropped, with no queueing.
- Band candidate from signed integer T:
  - 0: T ≤ 10, including all negatives
  - 1: 11–15
  - 2: 16–20
  - 3: 21–25
  - 4: 26–30
  - 5: 31–38
  - 6: ≥ 39
- Debounce: a counter increments in DONE when candidate ≠ band and candidate equals the previous candidate. Otherwise it loads 1 (candidate ≠ band) or 0 (candidate = band). When the count reaches STABLE_N, band ← candidate and the counter clears.
- Colour targets:
  - band 0 = 24'h180DF3, 1 = 24'h15D7EB, 2 = 24'h22DE6E, 3 = 24'h43C739
  - band 4 = 24'hDA6D00, 5 = 24'hFF1900, 6 = 24'hFF0000
  - For PWM_W ≠ 8, take the upper PWM_W bits of each 8-bit field (zero-extend if PWM_W > 8).
- Fade: the prescaler counts 0..FADE_DIV−1. On wrap, each of cur_R/G/B moves 1 toward its target, with no overshoot, and holds when equal.
- PWM: the counter runs 0..2^PWM_W−2, then wraps to 0. Duty registers latch cur_R/G/B when the counter is 0. led[2] = cnt < duty_R, and likewise for led[1]/G and led[0]/B. Maximum value gives 100% on; 0 gives 0%.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM IDLE; busy 0, bcd_valid 0, temp_sign 0, all digits 0, band 0
  - debounce counter 0, cur_R/G/B 0, duty registers 0, PWM counter 0, prescaler 0, hence led = 3'b000
- temp_valid sampled at edge N: busy = 1 from N through N+10. Digits and temp_sign update, and bcd_valid pulses, at edge N+10. busy = 0 from N+11. The earliest next accepted sample is at edge N+11.
- band updates at the same edge as bcd_valid when the debounce threshold is met.
- Reset mid-conversion aborts with no bcd_valid; the outputs return to their reset values.
- A new target mid-fade redirects immediately: each channel steps from its current value toward the new target.
- A duty change never takes effect mid-period; it applies only at a counter-0 latch.

## Test plan
- temp_raw = 13'h0190 (25 °C), valid at N → busy N..N+10, bcd_valid at N+10, sign 0, digits 0/2/5.
- temp_raw = 13'h1FF0 (−1 °C) → sign 1, digits 0/0/1, candidate 0. Then 13'h1000 (−256 °C) → sign 1, digits 2/5/6.
- Pulse temp_valid at N+3 during busy → ignored; exactly one bcd_valid, and the result matches the N sample.
- STABLE_N = 3, band 0: three 25 °C samples → band = 3 after the third bcd_valid. Alternating 25/12 °C → band stays 0.
- PWM_W = 8, FADE_DIV = 4, band forced to 6 → cur_R reaches 255 after 1020 cycles; led[2] then constantly 1, led[1:0] constantly 0.
- rst_n low at N+5 of a conversion → no bcd_valid, all outputs 0. The next sample converts correctly.
